// File: rtl/rdata_pkg.sv
// rdata_pkg: shared state encoding, status-word layout and sizing helpers for rdata_snap_mux
package rdata_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        BURST = 2'd2
    } state_t;

    // Status word bit positions, counted down from the top of the bus
    localparam int OVR_FROM_TOP = 1;
    localparam int VLD_FROM_TOP = 2;
    localparam int CNT_W        = 8;

    function automatic int calc_wpc(input int dw, input int bw);
        return (dw + bw - 1) / bw;
    endfunction

    function automatic int calc_aw(input int nch, input int wpc);
        return $clog2(nch * wpc + 1);
    endfunction

endpackage

// File: rtl/rdata_word_sel.sv
// rdata_word_sel: combinational selector from shadow bank to one readout word
//   bank   : captured channels, channel k at [k*DW +: DW]
//   status : status word returned for address 0
//   addr   : word address (0 = status, 1.. = channel words, beyond = 0)
//   word   : selected readout word
module rdata_word_sel import rdata_pkg::*; #(
    parameter int NCH = 8,
    parameter int DW  = 20,
    parameter int BW  = 16,
    localparam int WPC = calc_wpc(DW, BW),
    localparam int AW  = calc_aw(NCH, WPC)
) (
    input  logic [NCH*DW-1:0] bank,
    input  logic [BW-1:0]     status,
    input  logic [AW-1:0]     addr,
    output logic [BW-1:0]     word
);

    localparam int NW = NCH * WPC;
    localparam int PW = WPC * BW;

    // Each channel is zero-extended to a whole number of bus words
    logic [NW*BW-1:0] padded;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign padded[k*PW +: PW] = PW'(bank[k*DW +: DW]);
    end

    always_comb begin
        word = (addr == '0) ? status : '0;
        for (int i = 0; i < NW; i++)
            if (addr == AW'(i + 1)) word = padded[i*BW +: BW];
    end

endmodule

// File: rtl/rdata_snap_mux.sv
// rdata_snap_mux: atomic multi-channel snapshot with addressed and burst word readout
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : live channel data, channel k at [k*DW +: DW]
//   snap, lock  : capture strobe; lock protects an unread snapshot
//   rd_en, rd_addr, auto_inc : single read, or burst start when auto_inc=1
//   rd_next     : advance burst by one word
//   dout, dout_vld : registered read data and its one-cycle qualifier
//   snap_valid  : snapshot held and not fully read out
//   burst_done  : pulses with the last burst word
module rdata_snap_mux import rdata_pkg::*; #(
    parameter int NCH = 8,
    parameter int DW  = 20,
    parameter int BW  = 16,
    localparam int WPC = calc_wpc(DW, BW),
    localparam int AW  = calc_aw(NCH, WPC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] din,
    input  logic              snap,
    input  logic              lock,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    input  logic              auto_inc,
    input  logic              rd_next,
    output logic [BW-1:0]     dout,
    output logic              dout_vld,
    output logic              snap_valid,
    output logic              burst_done
);

    localparam int NW = NCH * WPC;

    state_t            state, state_nxt;
    logic [NCH*DW-1:0] bank;
    logic [AW-1:0]     ptr, ptr_inc, sel_addr;
    logic [CNT_W-1:0]  snap_cnt;
    logic              overrun;
    logic [BW-1:0]     status, word;
    logic              capture, ovr_set, direct, start, adv, fire, done;

    assign ptr_inc = ptr + AW'(1);

    always_comb begin
        capture  = snap && (state == EMPTY || !lock);
        ovr_set  = snap && state != EMPTY && lock;
        direct   = rd_en && !auto_inc;
        start    = rd_en && auto_inc && state == HELD;
        // A single read in the same cycle takes the bus; the burst waits
        adv      = rd_next && state == BURST && !direct;
        sel_addr = adv ? ptr_inc : rd_addr;
        fire     = direct || start || adv;
        done     = (start || adv) && sel_addr == AW'(NW);
    end

    always_comb begin
        status                  = BW'(snap_cnt);
        status[BW-OVR_FROM_TOP] = overrun;
        status[BW-VLD_FROM_TOP] = snap_valid;
    end

    // Reads see the pre-capture bank, so a same-cycle snap never tears a word
    rdata_word_sel #(.NCH(NCH), .DW(DW), .BW(BW)) u_sel (
        .bank   (bank),
        .status (status),
        .addr   (sel_addr),
        .word   (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == EMPTY && capture) state_nxt = HELD;
        if (start) state_nxt = BURST;
        // A snapshot taken as the burst finishes is itself unread
        if (done) state_nxt = capture ? HELD : EMPTY;
    end

    always_comb snap_valid = (state != EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank       <= '0;
            ptr        <= '0;
            snap_cnt   <= '0;
            overrun    <= 1'b0;
            dout       <= '0;
            dout_vld   <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            if (capture) begin
                bank     <= din;
                snap_cnt <= snap_cnt + CNT_W'(1);
            end
            if (start || adv) ptr <= sel_addr;
            overrun    <= ovr_set || (overrun && !(fire && sel_addr == '0));
            dout       <= fire ? word : dout;
            dout_vld   <= fire;
            burst_done <= done;
        end
    end

endmodule

// File: tb/tb_rdata_snap_mux.sv
// tb_rdata_snap_mux: scoreboard bench for rdata_snap_mux (default build plus a 3x36/16 build)
module tb_rdata_snap_mux;

    localparam int NCH = 8;
    localparam int DW  = 20;
    localparam int BW  = 16;
    localparam int NW  = 16;
    localparam int AW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NCH*DW-1:0] din;
    logic              snap, lock, rd_en, auto_inc, rd_next;
    logic [AW-1:0]     rd_addr;
    logic [BW-1:0]     dout;
    logic              dout_vld, snap_valid, burst_done;

    logic [107:0] din2;
    logic         snap2, rd_en2;
    logic         lock2 = 1'b0, auto_inc2 = 1'b0, rd_next2 = 1'b0;
    logic [3:0]   rd_addr2;
    logic [15:0]  dout2;
    logic         dout_vld2, snap_valid2, burst_done2;

    rdata_snap_mux u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .snap(snap), .lock(lock),
        .rd_en(rd_en), .rd_addr(rd_addr), .auto_inc(auto_inc), .rd_next(rd_next),
        .dout(dout), .dout_vld(dout_vld), .snap_valid(snap_valid), .burst_done(burst_done)
    );

    rdata_snap_mux #(.NCH(3), .DW(36), .BW(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .snap(snap2), .lock(lock2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .auto_inc(auto_inc2), .rd_next(rd_next2),
        .dout(dout2), .dout_vld(dout_vld2), .snap_valid(snap_valid2), .burst_done(burst_done2)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] m_bank [NCH];
    logic [7:0]    m_cnt;
    logic          m_ovr, m_valid;
    logic [BW:0]   sb [$];
    logic [15:0]   sb2 [$];

    function automatic logic [BW-1:0] exp_word(input int a);
        logic [2*BW-1:0] p;
        if (a == 0) return {m_ovr, m_valid, 6'b0, m_cnt};
        if (a > NW) return '0;
        p = {12'b0, m_bank[(a-1)/2]};
        return p[((a-1)%2)*BW +: BW];
    endfunction

    task automatic model_snap(input bit lk);
        if (!m_valid || !lk) begin
            for (int k = 0; k < NCH; k++) m_bank[k] = din[k*DW +: DW];
            m_cnt   = m_cnt + 8'd1;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) m_bank[k] = '0;
        m_cnt = 8'd0; m_ovr = 1'b0; m_valid = 1'b0;
        sb.delete();
    endtask

    task automatic rand_din();
        for (int k = 0; k < NCH; k++) din[k*DW +: DW] = DW'($urandom);
    endtask

    // Drives one cycle of stimulus, then returns all strobes to idle
    task automatic step(input bit snp, input bit lk, input bit rd, input bit ai, input bit nx, input int ad);
        snap = snp; lock = lk; rd_en = rd; auto_inc = ai; rd_next = nx; rd_addr = AW'(ad);
        @(negedge clk);
        snap = 1'b0; lock = 1'b0; rd_en = 1'b0; auto_inc = 1'b0; rd_next = 1'b0; rd_addr = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({dout, dout_vld, snap_valid, burst_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: dout=%h vld=%b sv=%b bd=%b, need all 0", dout, dout_vld, snap_valid, burst_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [BW:0] e;
        int          ads [3] = '{1, 2, 0};
        logic [15:0] lit [3] = '{16'hBCDE, 16'h000A, 16'h4001};
        rand_din();
        din[0 +: DW] = 20'hABCDE;
        model_snap(1'b0);
        step(1, 0, 0, 0, 0, 0);
        n_chk++;
        if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL basic_snap_valid: got %b need 1", snap_valid); end
        for (int i = 0; i < 3; i++) begin
            sb.push_back({1'b0, lit[i]});
            step(0, 0, 1, 0, 0, ads[i]);
            n_chk++;
            if (dout_vld !== 1'b1 || sb.size() == 0) begin
                n_fail++; $display("FAIL basic_vld addr=%0d: dout_vld=%b need 1", ads[i], dout_vld);
            end else begin
                e = sb.pop_front();
                if ({burst_done, dout} !== e) begin n_fail++; $display("FAIL basic_data addr=%0d: got %h need %h", ads[i], {burst_done, dout}, e); end
            end
            step(0, 0, 0, 0, 0, 0);
            n_chk++;
            if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL basic_pulse addr=%0d: dout_vld=%b need 0", ads[i], dout_vld); end
        end
    endtask

    task automatic test_burst();
        logic [BW:0] e;
        step(0, 0, 0, 0, 1, 0);
        n_chk++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL next_in_held: dout_vld=%b need 0", dout_vld); end
        for (int a = 1; a <= NW; a++) begin
            sb.push_back({a == NW, exp_word(a)});
            step(0, 0, a == 1, a == 1, a != 1, (a == 1) ? 1 : 0);
            n_chk++;
            if (dout_vld !== 1'b1 || sb.size() == 0) begin
                n_fail++; $display("FAIL burst_vld word=%0d: dout_vld=%b need 1", a, dout_vld);
            end else begin
                e = sb.pop_front();
                if ({burst_done, dout} !== e) begin n_fail++; $display("FAIL burst_word=%0d: got %h need %h", a, {burst_done, dout}, e); end
            end
        end
        m_valid = 1'b0;
        n_chk++;
        if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL burst_snap_valid: got %b need 0", snap_valid); end
    endtask

    task automatic test_lock();
        logic [BW:0] e;
        bit snp [10] = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 0};
        bit lk  [10] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        bit rd  [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        int ad  [10] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            if (snp[i]) rand_din();
            if (rd[i]) begin
                sb.push_back({1'b0, exp_word(ad[i])});
                if (ad[i] == 0) m_ovr = 1'b0;
            end
            if (snp[i]) model_snap(lk[i]);
            step(snp[i], lk[i], rd[i], 0, 0, ad[i]);
            n_chk++;
            if (dout_vld !== rd[i]) begin
                n_fail++; $display("FAIL lock_vld step=%0d: dout_vld=%b need %b", i, dout_vld, rd[i]);
            end else if (rd[i]) begin
                e = sb.pop_front();
                if ({burst_done, dout} !== e) begin n_fail++; $display("FAIL lock_data step=%0d: got %h need %h", i, {burst_done, dout}, e); end
            end
        end
    endtask

    task automatic test_oob();
        logic [BW:0] e;
        int ads [3] = '{17, 31, 16};
        for (int i = 0; i < 3; i++) begin
            sb.push_back({1'b0, exp_word(ads[i])});
            step(0, 0, 1, 0, 0, ads[i]);
            n_chk++;
            if (dout_vld !== 1'b1 || sb.size() == 0) begin
                n_fail++; $display("FAIL oob_vld addr=%0d: dout_vld=%b need 1", ads[i], dout_vld);
            end else begin
                e = sb.pop_front();
                if ({burst_done, dout} !== e) begin n_fail++; $display("FAIL oob_data addr=%0d: got %h need %h", ads[i], {burst_done, dout}, e); end
            end
        end
    endtask

    task automatic test_reset_midburst();
        logic [BW:0] e;
        for (int a = 1; a <= 5; a++) begin
            sb.push_back({1'b0, exp_word(a)});
            step(0, 0, a == 1, a == 1, a != 1, (a == 1) ? 1 : 0);
            n_chk++;
            if (dout_vld !== 1'b1 || sb.size() == 0) begin
                n_fail++; $display("FAIL mid_vld word=%0d: dout_vld=%b need 1", a, dout_vld);
            end else begin
                e = sb.pop_front();
                if ({burst_done, dout} !== e) begin n_fail++; $display("FAIL mid_word=%0d: got %h need %h", a, {burst_done, dout}, e); end
            end
        end
        rst_n = 1'b0;
        rd_next = 1'b1;
        #1;
        n_chk++;
        if ({dout, dout_vld, snap_valid, burst_done} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: dout=%h vld=%b sv=%b bd=%b, need all 0", dout, dout_vld, snap_valid, burst_done);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (burst_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done: burst_done=%b need 0", burst_done); end
        rst_n = 1'b1;
        rd_next = 1'b0;
        model_reset();
        @(negedge clk);
        n_chk++;
        if ({dout_vld, burst_done, snap_valid} !== 3'b000) begin
            n_fail++; $display("FAIL post_reset_idle: vld=%b bd=%b sv=%b need 000", dout_vld, burst_done, snap_valid);
        end
        step(0, 0, 1, 1, 0, 1);
        n_chk++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL burst_in_empty: dout_vld=%b need 0", dout_vld); end
        rand_din();
        model_snap(1'b0);
        step(1, 0, 0, 0, 0, 0);
        sb.push_back({1'b0, exp_word(0)});
        step(0, 0, 1, 0, 0, 0);
        n_chk++;
        if (dout_vld !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL post_status_vld: dout_vld=%b need 1", dout_vld);
        end else begin
            e = sb.pop_front();
            if ({burst_done, dout} !== e) begin n_fail++; $display("FAIL post_status: got %h need %h", {burst_done, dout}, e); end
        end
        n_chk++;
        if (dout[7:0] !== 8'h01) begin n_fail++; $display("FAIL post_snap_cnt: got %h need 01", dout[7:0]); end
        sb.push_back({1'b0, exp_word(3)});
        step(0, 0, 1, 0, 0, 3);
        n_chk++;
        if (dout_vld !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL post_read_vld: dout_vld=%b need 1", dout_vld);
        end else begin
            e = sb.pop_front();
            if ({burst_done, dout} !== e) begin n_fail++; $display("FAIL post_read: got %h need %h", {burst_done, dout}, e); end
        end
    endtask

    task automatic test_wide();
        logic [15:0] e;
        int          ads [4] = '{9, 8, 7, 10};
        logic [15:0] lit [4] = '{16'h000F, 16'h1234, 16'h5678, 16'h0000};
        for (int k = 0; k < 3; k++) din2[k*36 +: 36] = {4'($urandom), $urandom};
        din2[72 +: 36] = 36'hF_1234_5678;
        snap2 = 1'b1;
        @(negedge clk);
        snap2 = 1'b0;
        n_chk++;
        if (snap_valid2 !== 1'b1) begin n_fail++; $display("FAIL wide_snap_valid: got %b need 1", snap_valid2); end
        for (int i = 0; i < 4; i++) begin
            sb2.push_back(lit[i]);
            rd_en2 = 1'b1; rd_addr2 = 4'(ads[i]);
            @(negedge clk);
            rd_en2 = 1'b0;
            n_chk++;
            if (dout_vld2 !== 1'b1 || sb2.size() == 0) begin
                n_fail++; $display("FAIL wide_vld addr=%0d: dout_vld=%b need 1", ads[i], dout_vld2);
            end else begin
                e = sb2.pop_front();
                if (dout2 !== e) begin n_fail++; $display("FAIL wide_data addr=%0d: got %h need %h", ads[i], dout2, e); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din = '0; snap = 1'b0; lock = 1'b0; rd_en = 1'b0; auto_inc = 1'b0; rd_next = 1'b0; rd_addr = '0;
        din2 = '0; snap2 = 1'b0; rd_en2 = 1'b0; rd_addr2 = '0;
        model_reset();
        test_reset();
        test_basic();
        test_burst();
        test_lock();
        test_oob();
        test_reset_midburst();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rdata_snap_mux.md
RDATA_SNAP_MUX -- requirements
Module: rdata_snap_mux

Interface
REQ-001 SHALL have parameter NCH, default 8, number of input data channels (1..16).
REQ-002 SHALL have parameter DW, default 20, width of each channel word (1..64).
REQ-003 SHALL have parameter BW, default 16, readout bus width; WPC = ceil(DW/BW) words per channel; AW = clog2(NCH*WPC+1).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port din, input, NCH*DW, channel k occupies bits [k*DW +: DW].
REQ-007 SHALL have port snap, input, 1, one-cycle strobe that captures all channels atomically.
REQ-008 SHALL have port lock, input, 1, 1 = ignore snap while an unread snapshot is held.
REQ-009 SHALL have port rd_en, input, 1, read request for word rd_addr.
REQ-010 SHALL have port rd_addr, input, AW, word address for a read or burst start.
REQ-011 SHALL have port auto_inc, input, 1, sampled with rd_en; 1 = start burst.
REQ-012 SHALL have port rd_next, input, 1, advance burst pointer by one word.
REQ-013 SHALL have port dout, output, BW, registered read data.
REQ-014 SHALL have port dout_vld, output, 1, one-cycle pulse qualifying dout.
REQ-015 SHALL have port snap_valid, output, 1, snapshot held and not fully read.
REQ-016 SHALL have port burst_done, output, 1, one-cycle pulse after the last burst word.

Function
REQ-017 SHALL map addresses: 0 = status; 1 + k*WPC + j = channel k, word j (j=0 least-significant BW bits).
REQ-018 SHALL zero-extend the top word of a channel when DW is not a multiple of BW.
REQ-019 SHALL drive status word = {overrun, snap_valid, zero pad, snap_cnt[7:0]} with overrun at BW-1, snap_valid at BW-2, and snap_cnt in the low 8 bits.
REQ-020 SHALL return 0 for addresses > NCH*WPC; the bus SHALL never be high-impedance.
REQ-021 SHALL implement states EMPTY, HELD, BURST.
REQ-022 SHALL, on snap in EMPTY, capture din into the shadow bank, increment snap_cnt (wrap 255->0), and go to HELD.
REQ-023 SHALL, on snap in HELD or BURST: with lock=1, keep the bank unchanged and set overrun; with lock=0, recapture, increment snap_cnt, and remain in the same state.
REQ-024 SHALL, on rd_en with auto_inc=0 in any state, present word rd_addr on dout with dout_vld one cycle later (latency 1).
REQ-025 SHALL, on rd_en with auto_inc=1 in HELD, load ptr=rd_addr, output word ptr after 1 cycle, and enter BURST.
REQ-026 SHALL, on rd_next in BURST, increment ptr and output the new word with latency 1.
REQ-027 SHALL, when ptr reaches NCH*WPC and that word is output, pulse burst_done with the same dout_vld and go to EMPTY.
REQ-028 SHALL clear overrun on a read of address 0, unless snap is set in the same cycle with lock=1 (set wins).
REQ-029 SHALL ignore rd_en with auto_inc=1 in EMPTY or BURST, and rd_next outside BURST.
REQ-030 SHALL, when snap and rd_en/rd_next occur in the same cycle, read from the pre-capture bank.
REQ-031 SHALL drive snap_valid = 1 in HELD and BURST.

Reset
REQ-032 SHALL, with rst_n low, force state=EMPTY, shadow bank=0, ptr=0, snap_cnt=0, overrun=0, dout=0, dout_vld=0, burst_done=0, snap_valid=0.
REQ-033 SHALL, if reset occurs mid-burst, abort the burst with no burst_done; the first post-reset snap SHALL yield snap_cnt=1.

Structure
REQ-034 SHALL place the state encoding, the status-bit positions, and the WPC/AW calculation functions in the shared package rdata_pkg.
REQ-035 SHALL use one sub-module rdata_word_sel: combinational shadow-bank-to-word selector, parametrised on NCH/DW/BW.

Verification
REQ-036 SHALL cover: defaults, din ch0=20'hABCDE, snap, read addr 1 then 2 -> dout 16'hBCDE then 16'h000A, each with dout_vld 1 cycle after rd_en.
REQ-037 SHALL cover: burst from addr 1 with 15 rd_next -> 16 words in order, burst_done with word 16, snap_valid falls to 0.
REQ-038 SHALL cover: lock=1, snap, snap -> bank holds first capture, status bit15=1; read addr 0 -> next status bit15=0.
REQ-039 SHALL cover: read addr 17 -> dout 16'h0000 with dout_vld=1.
REQ-040 SHALL cover: rst_n low at burst word 5 -> all outputs 0, no burst_done; next snap -> status low byte 8'h01.
REQ-041 SHALL cover: NCH=3, DW=36, BW=16 -> WPC=3; channel 2 word 2 at addr 9 -> upper 4 bits zero-extended.
